// File: rtl/lc3_pkg.sv
// Shared LC-3 pipeline definitions: writeback source encodings, PSR layout and datapath sizes.
package lc3_pkg;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned IDX_W    = $clog2(NUM_REGS);
   localparam int unsigned WBC_W    = 2;
   localparam int unsigned PSR_W    = 3;

   localparam logic [WBC_W-1:0] WB_ALU  = 2'd0;
   localparam logic [WBC_W-1:0] WB_MEM  = 2'd1;
   localparam logic [WBC_W-1:0] WB_PC   = 2'd2;
   localparam logic [WBC_W-1:0] WB_NONE = 2'd3;

   localparam int unsigned PSR_N = 2;
   localparam int unsigned PSR_Z = 1;
   localparam int unsigned PSR_P = 0;

   localparam logic [PSR_W-1:0] PSR_RESET = 3'b010;

   // One-hot condition code of a two's-complement value.
   function automatic logic [PSR_W-1:0] psr_of(input logic [DATA_W-1:0] v);
      logic [PSR_W-1:0] cc;
      cc = '0;
      if (v[DATA_W-1])
         cc[PSR_N] = 1'b1;
      else if (v == '0)
         cc[PSR_Z] = 1'b1;
      else
         cc[PSR_P] = 1'b1;
      return cc;
   endfunction

endpackage

// File: rtl/reg_file.sv
// Eight-entry general register file: one synchronous write port, two async read ports with
// write-to-read bypass.
module reg_file
   import lc3_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [IDX_W-1:0]  i_raddr1,
   input  logic [IDX_W-1:0]  i_raddr2,
   output logic [DATA_W-1:0] o_rdata1,
   output logic [DATA_W-1:0] o_rdata2
);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              w_byp1;
   logic              w_byp2;

   // Reset wins over a coincident write.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < NUM_REGS; i++)
            r_regs[i] <= '0;
      end else if (i_we) begin
         r_regs[i_waddr] <= i_wdata;
      end
   end

   // Bypass only when the write will actually land on this edge.
   assign w_byp1 = i_we && !i_rst && (i_waddr == i_raddr1);
   assign w_byp2 = i_we && !i_rst && (i_waddr == i_raddr2);

   assign o_rdata1 = w_byp1 ? i_wdata : r_regs[i_raddr1];
   assign o_rdata2 = w_byp2 ? i_wdata : r_regs[i_raddr2];

endmodule

// File: rtl/writeback.sv
// LC-3 writeback stage: selects the result source, writes the register file and tracks the PSR.
module writeback
   import lc3_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              enable_writeback,
   input  logic [WBC_W-1:0]  W_control,
   input  logic [DATA_W-1:0] aluout,
   input  logic [DATA_W-1:0] pcout,
   input  logic [DATA_W-1:0] memout,
   input  logic [IDX_W-1:0]  dr,
   input  logic [IDX_W-1:0]  sr1,
   input  logic [IDX_W-1:0]  sr2,
   output logic [DATA_W-1:0] VSR1,
   output logic [DATA_W-1:0] VSR2,
   output logic [PSR_W-1:0]  psr
);

   logic [DATA_W-1:0] w_wdata;
   logic              w_we;
   logic [PSR_W-1:0]  r_psr;

   // Result source select; WB_NONE leaves data don't-care since no write occurs.
   always_comb begin
      w_wdata = '0;
      case (W_control)
         WB_ALU:  w_wdata = aluout;
         WB_MEM:  w_wdata = memout;
         WB_PC:   w_wdata = pcout;
         default: w_wdata = '0;
      endcase
   end

   assign w_we = enable_writeback && (W_control != WB_NONE);

   always_ff @(posedge clk) begin
      if (rst)
         r_psr <= PSR_RESET;
      else if (w_we)
         r_psr <= psr_of(w_wdata);
   end

   assign psr = r_psr;

   reg_file u_reg_file (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_we     (w_we),
      .i_waddr  (dr),
      .i_wdata  (w_wdata),
      .i_raddr1 (sr1),
      .i_raddr2 (sr2),
      .o_rdata1 (VSR1),
      .o_rdata2 (VSR2)
   );

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed scenarios plus randomized traffic against an
// array-based reference model.
module tb_writeback;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable_writeback;
   logic [1:0]  W_control;
   logic [15:0] aluout;
   logic [15:0] pcout;
   logic [15:0] memout;
   logic [2:0]  dr;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic [15:0] VSR1;
   logic [15:0] VSR2;
   logic [2:0]  psr;

   int n_run  = 0;
   int n_fail = 0;

   logic [15:0] m_regs [8];
   logic [2:0]  m_psr;

   writeback dut (
      .clk              (clk),
      .rst              (rst),
      .enable_writeback (enable_writeback),
      .W_control        (W_control),
      .aluout           (aluout),
      .pcout            (pcout),
      .memout           (memout),
      .dr               (dr),
      .sr1              (sr1),
      .sr2              (sr2),
      .VSR1             (VSR1),
      .VSR2             (VSR2),
      .psr              (psr)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] m_data();
      if (W_control == 2'd1) return memout;
      if (W_control == 2'd2) return pcout;
      return aluout;
   endfunction

   function automatic bit m_pending();
      return (rst == 1'b0) && enable_writeback && (W_control != 2'd3);
   endfunction

   function automatic logic [15:0] m_read(input logic [2:0] idx);
      if (m_pending() && dr == idx) return m_data();
      return m_regs[idx];
   endfunction

   // Advance the model with the current inputs, then let the DUT see the same edge.
   task automatic tick();
      logic [15:0] d;
      if (rst) begin
         for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
         m_psr = 3'b010;
      end else if (m_pending()) begin
         d = m_data();
         m_regs[dr] = d;
         if ($signed(d) < 0)      m_psr = 3'b100;
         else if (d == 16'h0000)  m_psr = 3'b010;
         else                     m_psr = 3'b001;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rst = 1'b0; enable_writeback = 1'b0; W_control = 2'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1; enable_writeback = 1'b1; W_control = 2'd0; aluout = 16'h1234;
      pcout = 16'h0; memout = 16'h0; dr = 3'd0; sr1 = 3'd0; sr2 = 3'd0;
      tick();
      tick();
      idle();
      n_run++;
      if (psr !== 3'b010) begin
         n_fail++; $display("FAIL reset_psr: got %b want 010", psr);
      end
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i); sr2 = 3'(7 - i); #1;
         n_run++;
         if (VSR1 !== 16'h0000 || VSR2 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_reg%0d: VSR1=%h VSR2=%h want 0000", i, VSR1, VSR2);
         end
      end
   endtask

   task automatic test_alu_write();
      dr = 3'd3; W_control = 2'd0; aluout = 16'h8001; enable_writeback = 1'b1; sr1 = 3'd0;
      tick();
      idle(); sr1 = 3'd3; #1;
      n_run++;
      if (VSR1 !== 16'h8001 || psr !== 3'b100) begin
         n_fail++; $display("FAIL alu_write: VSR1=%h psr=%b want 8001/100", VSR1, psr);
      end
   endtask

   task automatic test_source_select();
      dr = 3'd5; W_control = 2'd1; memout = 16'h0000; aluout = 16'h5555; pcout = 16'h6666;
      enable_writeback = 1'b1;
      tick();
      idle(); sr1 = 3'd5; #1;
      n_run++;
      if (VSR1 !== 16'h0000 || psr !== 3'b010) begin
         n_fail++; $display("FAIL mem_select: VSR1=%h psr=%b want 0000/010", VSR1, psr);
      end
      dr = 3'd6; W_control = 2'd2; pcout = 16'h3005; memout = 16'h9999; aluout = 16'h0000;
      enable_writeback = 1'b1;
      tick();
      idle(); sr2 = 3'd6; #1;
      n_run++;
      if (VSR2 !== 16'h3005 || psr !== 3'b001) begin
         n_fail++; $display("FAIL pc_select: VSR2=%h psr=%b want 3005/001", VSR2, psr);
      end
   endtask

   task automatic test_no_write();
      dr = 3'd6; sr1 = 3'd6; W_control = 2'd3; enable_writeback = 1'b1;
      aluout = 16'h8000; memout = 16'h8000; pcout = 16'h8000; #1;
      n_run++;
      if (VSR1 !== 16'h3005) begin
         n_fail++; $display("FAIL nowrite_bypass: VSR1=%h want 3005", VSR1);
      end
      tick();
      n_run++;
      if (VSR1 !== 16'h3005 || psr !== 3'b001) begin
         n_fail++; $display("FAIL nowrite_wc3: VSR1=%h psr=%b want 3005/001", VSR1, psr);
      end
      W_control = 2'd0; enable_writeback = 1'b0; aluout = 16'hFFFF;
      tick();
      n_run++;
      if (VSR1 !== 16'h3005 || psr !== 3'b001) begin
         n_fail++; $display("FAIL nowrite_en0: VSR1=%h psr=%b want 3005/001", VSR1, psr);
      end
   endtask

   task automatic test_bypass();
      dr = 3'd2; sr1 = 3'd2; sr2 = 3'd2; W_control = 2'd0; aluout = 16'h00FF;
      enable_writeback = 1'b1; #1;
      n_run++;
      if (VSR1 !== 16'h00FF || VSR2 !== 16'h00FF) begin
         n_fail++; $display("FAIL bypass_same_cycle: VSR1=%h VSR2=%h want 00FF", VSR1, VSR2);
      end
      tick();
      idle(); #1;
      n_run++;
      if (VSR1 !== 16'h00FF || VSR2 !== 16'h00FF || psr !== 3'b001) begin
         n_fail++;
         $display("FAIL bypass_after: VSR1=%h VSR2=%h psr=%b want 00FF/00FF/001", VSR1, VSR2, psr);
      end
   endtask

   task automatic test_reset_mid();
      dr = 3'd7; W_control = 2'd0; aluout = 16'h7FFF; enable_writeback = 1'b1; sr1 = 3'd7;
      tick();
      rst = 1'b1; aluout = 16'hAAAA; #1;
      n_run++;
      if (VSR1 !== 16'h7FFF) begin
         n_fail++; $display("FAIL reset_no_bypass: VSR1=%h want 7FFF", VSR1);
      end
      tick();
      idle(); #1;
      n_run++;
      if (VSR1 !== 16'h0000 || psr !== 3'b010) begin
         n_fail++; $display("FAIL reset_mid: VSR1=%h psr=%b want 0000/010", VSR1, psr);
      end
   endtask

   task automatic test_random();
      logic [15:0] e1;
      logic [15:0] e2;
      for (int it = 0; it < 300; it++) begin
         rst              = ($urandom_range(0, 31) == 0);
         enable_writeback = ($urandom_range(0, 3) != 0);
         W_control        = 2'($urandom_range(0, 3));
         dr               = 3'($urandom_range(0, 7));
         sr1              = 3'($urandom_range(0, 7));
         sr2              = ($urandom_range(0, 3) == 0) ? sr1 : 3'($urandom_range(0, 7));
         if ($urandom_range(0, 2) == 0) sr1 = dr;
         case ($urandom_range(0, 5))
            0:       aluout = 16'h0000;
            1:       aluout = 16'h8000;
            default: aluout = 16'($urandom);
         endcase
         memout = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
         pcout  = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
         #1;
         e1 = m_read(sr1);
         e2 = m_read(sr2);
         n_run++;
         if (VSR1 !== e1 || VSR2 !== e2) begin
            n_fail++;
            $display("FAIL rand_read it=%0d: VSR1=%h VSR2=%h want %h/%h", it, VSR1, VSR2, e1, e2);
         end
         tick();
         n_run++;
         if (psr !== m_psr) begin
            n_fail++; $display("FAIL rand_psr it=%0d: psr=%b want %b", it, psr, m_psr);
         end
      end
      idle();
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i); sr2 = 3'(i); #1;
         n_run++;
         if (VSR1 !== m_regs[i] || VSR2 !== m_regs[i]) begin
            n_fail++;
            $display("FAIL rand_final_r%0d: VSR1=%h VSR2=%h want %h", i, VSR1, VSR2, m_regs[i]);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'hxxxx;
      m_psr = 3'bxxx;
      test_reset();
      test_alu_write();
      test_source_select();
      test_no_write();
      test_bypass();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
